// File: rtl/enigma_seq_ctrl.sv
// Sequencer for a chain of rotor datapaths: routes one character through the rotors, then odometer-steps them.
// Build option PASSTHRU_EN: non-letters bypass the rotors instead of raising err.
module enigma_seq_ctrl #(
  parameter int unsigned NUM_ROTORS = 3,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned STEP_MOD   = 26
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  output logic                    cfg_busy_err,
  input  logic                    mode_dec,
  input  logic                    in_valid,
  input  logic [7:0]              in_char,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [7:0]              out_char,
  output logic                    err,
  output logic [NUM_ROTORS-1:0]   rot_set,
  output logic [NUM_ROTORS-1:0]   rot_valid,
  output logic [NUM_ROTORS-1:0]   rot_en,
  output logic                    rot_dec,
  output logic [7:0]              rot_din,
  input  logic [8*NUM_ROTORS-1:0] rot_dout,
  input  logic [NUM_ROTORS-1:0]   rot_done,
  output logic [5*NUM_ROTORS-1:0] step_pos
);

  localparam int unsigned SW = 2;
  localparam int unsigned PW = 5;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STEP, S_OUT} state_e;

  state_e                        state_q, state_d;
  logic [7:0]                    data_q, data_d;
  logic                          mode_q, mode_d;
  logic [SW-1:0]                 stage_q, stage_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic [NUM_ROTORS-1:0][PW-1:0] pos_q, pos_d;
  logic                          out_valid_q, out_valid_d;
  logic [7:0]                    out_char_q, out_char_d;
  logic                          err_q, err_d;
  logic                          cfg_busy_err_q, cfg_busy_err_d;
  logic [NUM_ROTORS-1:0]         rot_set_q, rot_set_d;
  logic [NUM_ROTORS-1:0]         rot_valid_q, rot_valid_d;
  logic [NUM_ROTORS-1:0]         rot_en_q, rot_en_d;
  logic                          alive_q;

  logic [3:0][7:0]               dout_a;
  logic [3:0]                    done_a;
  logic [NUM_ROTORS-1:0]         step_c;
  logic [SW-1:0]                 sel_r;
  logic                          is_letter;

  // Rotor visited at a given stage: forward for encrypt, reverse for decrypt.
  function automatic logic [SW-1:0] rotor_idx(input logic dec, input logic [SW-1:0] st);
    rotor_idx = dec ? (SW'(NUM_ROTORS - 1) - st) : st;
  endfunction

  function automatic logic [NUM_ROTORS-1:0] onehot(input logic [SW-1:0] idx);
    logic [3:0] oh;
    oh     = 4'b0001 << idx;
    onehot = oh[NUM_ROTORS-1:0];
  endfunction

  always_comb begin
    dout_a = '0;
    for (int k = 0; k < NUM_ROTORS; k++) dout_a[k] = rot_dout[8*k +: 8];
    done_a = 4'(rot_done);
  end

  // Odometer carry: rotor k steps when every lower rotor is stepping and wraps.
  always_comb begin
    step_c[0] = 1'b1;
    for (int k = 1; k < NUM_ROTORS; k++)
      step_c[k] = step_c[k-1] && (pos_q[k-1] == PW'(STEP_MOD - 1));
  end

  assign sel_r     = rotor_idx(mode_q, stage_q);
  assign is_letter = (in_char >= 8'h41) && (in_char <= 8'h5A);

  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    mode_d         = mode_q;
    stage_d        = stage_q;
    tmo_d          = tmo_q;
    pos_d          = pos_q;
    out_valid_d    = 1'b0;
    out_char_d     = out_char_q;
    err_d          = 1'b0;
    cfg_busy_err_d = 1'b0;
    rot_set_d      = '0;
    rot_valid_d    = '0;
    rot_en_d       = '0;

    if (cfg_we && ((state_q != S_IDLE) || (32'(cfg_sel) >= NUM_ROTORS))) cfg_busy_err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          for (int k = 0; k < NUM_ROTORS; k++) begin
            if (cfg_sel == SW'(k)) begin
              rot_set_d[k] = 1'b1;
              pos_d[k]     = '0;
            end
          end
        end else if (in_valid && alive_q) begin
          mode_d  = mode_dec;
          stage_d = '0;
          data_d  = in_char;
          if (is_letter) begin
            state_d     = S_ISSUE;
            rot_valid_d = onehot(rotor_idx(mode_dec, '0));
          end else begin
`ifdef PASSTHRU_EN
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_char_d  = in_char;
`else
            err_d       = 1'b1;
`endif
          end
        end
      end
      // tmo counts cycles since this stage's rot_valid.
      S_ISSUE: begin
        tmo_d   = TW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_a[sel_r]) begin
          data_d = dout_a[sel_r];
          if (stage_q == SW'(NUM_ROTORS - 1)) begin
            state_d  = S_STEP;
            rot_en_d = step_c;
            for (int k = 0; k < NUM_ROTORS; k++) begin
              if (step_c[k])
                pos_d[k] = (pos_q[k] == PW'(STEP_MOD - 1)) ? '0 : pos_q[k] + PW'(1);
            end
          end else begin
            stage_d     = stage_q + SW'(1);
            state_d     = S_ISSUE;
            rot_valid_d = onehot(rotor_idx(mode_q, stage_q + SW'(1)));
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_STEP: begin
        state_d     = S_OUT;
        out_valid_d = 1'b1;
        out_char_d  = data_q;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      data_q         <= '0;
      mode_q         <= 1'b0;
      stage_q        <= '0;
      tmo_q          <= '0;
      pos_q          <= '0;
      out_valid_q    <= 1'b0;
      out_char_q     <= '0;
      err_q          <= 1'b0;
      cfg_busy_err_q <= 1'b0;
      rot_set_q      <= '0;
      rot_valid_q    <= '0;
      rot_en_q       <= '0;
      alive_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      mode_q         <= mode_d;
      stage_q        <= stage_d;
      tmo_q          <= tmo_d;
      pos_q          <= pos_d;
      out_valid_q    <= out_valid_d;
      out_char_q     <= out_char_d;
      err_q          <= err_d;
      cfg_busy_err_q <= cfg_busy_err_d;
      rot_set_q      <= rot_set_d;
      rot_valid_q    <= rot_valid_d;
      rot_en_q       <= rot_en_d;
      alive_q        <= 1'b1;
    end
  end

  // alive_q keeps in_ready low while reset is asserted.
  assign in_ready     = alive_q && (state_q == S_IDLE) && !cfg_we;
  assign out_valid    = out_valid_q;
  assign out_char     = out_char_q;
  assign err          = err_q;
  assign cfg_busy_err = cfg_busy_err_q;
  assign rot_set      = rot_set_q;
  assign rot_valid    = rot_valid_q;
  assign rot_en       = rot_en_q;
  assign rot_dec      = mode_q;
  assign rot_din      = data_q;
  assign step_pos     = pos_q;

endmodule
